e2prom_rw_seq: RTL and testbench

E2PROM_RW_SEQ -- requirements
Module: e2prom_rw_seq

---
 rtl/e2prom_rw_seq_if.sv | 21 ++
 rtl/e2prom_rw_seq.sv | 212 +++++++++++++++++++++
 tb/tb_e2prom_rw_seq.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/e2prom_rw_seq_if.sv
// I2C driver transaction bus between the EEPROM test sequencer (master) and the byte-level I2C driver (slave).
interface e2prom_rw_seq_if;
    logic        i2c_exec;
    logic        i2c_rh_wl;
    logic        bit_ctrl;
    logic [15:0] i2c_addr;
    logic [7:0]  i2c_data_w;
    logic [7:0]  i2c_data_r;
    logic        i2c_done;
    logic        i2c_ack;

    modport master (
        output i2c_exec, i2c_rh_wl, bit_ctrl, i2c_addr, i2c_data_w,
        input  i2c_data_r, i2c_done, i2c_ack
    );

    modport slave (
        input  i2c_exec, i2c_rh_wl, bit_ctrl, i2c_addr, i2c_data_w,
        output i2c_data_r, i2c_done, i2c_ack
    );
endinterface

// File: rtl/e2prom_rw_seq.sv
// EEPROM write-then-read-back test sequencer driving a byte-level I2C driver.
// Optional macro E2P_ACK_RETRY_EN: retry a NACKed write up to 3 times after a WAIT_CYCLES back-off.
module e2prom_rw_seq #(
    parameter logic [15:0] BYTE_NUM    = 16'd256,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter logic [15:0] WAIT_CYCLES = 16'd5000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    e2prom_rw_seq_if.master       bus,
    output logic                  busy,
    output logic                  pass,
    output logic                  fail,
    output logic [15:0]           err_addr
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam logic [DATA_W-1:0] PATTERN = 8'hA5;

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, WR_DLY, RD_REQ, RD_WAIT, CHECK, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   offset_q, offset_d;
    logic [ADDR_W-1:0]   dly_q, dly_d;
    logic                exec_q, exec_d;
    logic                rh_wl_q, rh_wl_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_w_q, data_w_d;
    logic                busy_q, busy_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
    logic [ADDR_W-1:0]   err_q, err_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_nack_q, rd_nack_d;
`ifdef E2P_ACK_RETRY_EN
    localparam logic [1:0] MAX_RETRY = 2'd3;
    logic [1:0]          retry_q, retry_d;
    logic                retry_pend_q, retry_pend_d;
`endif

    logic [ADDR_W-1:0]   offset_inc;
    logic                last_byte;
    logic                dly_end;

    assign offset_inc = offset_q + ADDR_W'(1);
    assign last_byte  = (offset_inc == BYTE_NUM);
    assign dly_end    = ((17'(dly_q) + 17'd1) >= 17'(WAIT_CYCLES));

    // Next-state and next-register computation
    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        dly_d     = dly_q;
        exec_d    = 1'b0;
        rh_wl_d   = rh_wl_q;
        addr_d    = addr_q;
        data_w_d  = data_w_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        err_d     = err_q;
        rd_data_d = rd_data_q;
        rd_nack_d = rd_nack_q;
`ifdef E2P_ACK_RETRY_EN
        retry_d      = retry_q;
        retry_pend_d = retry_pend_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pass_d   = 1'b0;
                    fail_d   = 1'b0;
                    err_d    = '0;
                    offset_d = '0;
                    state_d  = WR_REQ;
`ifdef E2P_ACK_RETRY_EN
                    retry_d      = '0;
                    retry_pend_d = 1'b0;
`endif
                end
            end
            WR_REQ: state_d = WR_WAIT;
            WR_WAIT: begin
                if (bus.i2c_done) begin
                    if (!bus.i2c_ack) begin
                        dly_d   = '0;
                        state_d = WR_DLY;
`ifdef E2P_ACK_RETRY_EN
                        retry_d = '0;
                    end else if (retry_q < MAX_RETRY) begin
                        retry_d      = retry_q + 2'd1;
                        retry_pend_d = 1'b1;
                        dly_d        = '0;
                        state_d      = WR_DLY;
`endif
                    end else begin
                        fail_d  = 1'b1;
                        err_d   = addr_q;
                        state_d = DONE;
                    end
                end
            end
            WR_DLY: begin
                if (!dly_end) begin
                    dly_d = dly_q + ADDR_W'(1);
                end else begin
                    dly_d = '0;
`ifdef E2P_ACK_RETRY_EN
                    if (retry_pend_q) begin
                        retry_pend_d = 1'b0;
                        state_d      = WR_REQ;
                    end else
`endif
                    if (last_byte) begin
                        offset_d = '0;
                        state_d  = RD_REQ;
                    end else begin
                        offset_d = offset_inc;
                        state_d  = WR_REQ;
                    end
                end
            end
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: begin
                if (bus.i2c_done) begin
                    rd_data_d = bus.i2c_data_r;
                    rd_nack_d = bus.i2c_ack;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (rd_nack_q || (rd_data_q != (offset_q[DATA_W-1:0] ^ PATTERN))) begin
                    fail_d  = 1'b1;
                    err_d   = addr_q;
                    state_d = DONE;
                end else if (last_byte) begin
                    pass_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    offset_d = offset_inc;
                    state_d  = RD_REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Request strobe and payload are registered on entry to a request state
        if ((state_d == WR_REQ) || (state_d == RD_REQ)) begin
            exec_d  = 1'b1;
            rh_wl_d = (state_d == RD_REQ);
            addr_d  = BASE_ADDR + offset_d;
            if (state_d == WR_REQ) begin
                data_w_d = offset_d[DATA_W-1:0] ^ PATTERN;
            end
        end

        busy_d = (state_d != IDLE) && (state_d != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            offset_q  <= '0;
            dly_q     <= '0;
            exec_q    <= 1'b0;
            rh_wl_q   <= 1'b0;
            addr_q    <= '0;
            data_w_q  <= '0;
            busy_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            err_q     <= '0;
            rd_data_q <= '0;
            rd_nack_q <= 1'b0;
`ifdef E2P_ACK_RETRY_EN
            retry_q      <= '0;
            retry_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            dly_q     <= dly_d;
            exec_q    <= exec_d;
            rh_wl_q   <= rh_wl_d;
            addr_q    <= addr_d;
            data_w_q  <= data_w_d;
            busy_q    <= busy_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            rd_nack_q <= rd_nack_d;
`ifdef E2P_ACK_RETRY_EN
            retry_q      <= retry_d;
            retry_pend_q <= retry_pend_d;
`endif
        end
    end

    assign bus.i2c_exec   = exec_q;
    assign bus.i2c_rh_wl  = rh_wl_q;
    assign bus.bit_ctrl   = 1'b1;
    assign bus.i2c_addr   = addr_q;
    assign bus.i2c_data_w = data_w_q;
    assign busy           = busy_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign err_addr       = err_q;
endmodule

// File: tb/tb_e2prom_rw_seq.sv
// Directed bench for e2prom_rw_seq with a small behavioural EEPROM/I2C-driver model.
module tb_e2prom_rw_seq;
    localparam logic [15:0] BYTE_NUM    = 16'd4;
    localparam logic [15:0] BASE_ADDR   = 16'h0010;
    localparam logic [15:0] WAIT_CYCLES = 16'd8;
    // Model-edge spacing from a write's done pulse to the next exec: 1 + WAIT_CYCLES + 1
    localparam int GAP_EXP = 10;
    localparam int TIMEOUT = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, pass, fail;
    logic [15:0] err_addr;

    e2prom_rw_seq_if bus ();

    e2prom_rw_seq #(
        .BYTE_NUM(BYTE_NUM), .BASE_ADDR(BASE_ADDR), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.master),
        .busy(busy), .pass(pass), .fail(fail), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    // Model state and fault controls
    logic [7:0]  mem [256];
    int          wr_cnt [256];
    int          rd_cnt [256];
    int          cyc = 0;
    int          viol_exec = 0;
    int          viol_pf = 0;
    int          last_gap = 0;
    int          retry_gap = 0;
    int          rd_exec_cnt = 0;
    int          exec_total = 0;
    logic        pend = 1'b0;
    int          lat = 0;
    logic        p_rh = 1'b0;
    logic [15:0] p_addr = '0;
    logic [7:0]  p_data = '0;
    logic        prev_exec = 1'b0;
    int          last_wr_done_cyc = 0;
    logic [15:0] last_wr_addr = 16'hFFFF;
    int          nack_left = 0;

    logic        clr = 1'b0;
    logic        bad_rd_en = 1'b0;
    logic [15:0] bad_rd_addr = '0;
    logic [15:0] nack_addr = 16'hFFFF;
    int          nack_cfg = 0;

    initial begin
        bus.i2c_done   = 1'b0;
        bus.i2c_ack    = 1'b0;
        bus.i2c_data_r = 8'h00;
    end

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        prev_exec <= bus.i2c_exec;
        bus.i2c_done <= 1'b0;
        if (pass && fail) viol_pf <= viol_pf + 1;
        if (clr) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]    <= 8'h00;
                wr_cnt[i] <= 0;
                rd_cnt[i] <= 0;
            end
            viol_exec    <= 0;
            last_gap     <= 0;
            retry_gap    <= 0;
            rd_exec_cnt  <= 0;
            exec_total   <= 0;
            nack_left    <= nack_cfg;
            last_wr_addr <= 16'hFFFF;
        end else if (bus.i2c_exec) begin
            if (pend || prev_exec) viol_exec <= viol_exec + 1;
            exec_total <= exec_total + 1;
            pend   <= 1'b1;
            lat    <= 2;
            p_rh   <= bus.i2c_rh_wl;
            p_addr <= bus.i2c_addr;
            p_data <= bus.i2c_data_w;
            if (!bus.i2c_rh_wl) begin
                wr_cnt[bus.i2c_addr[7:0]] <= wr_cnt[bus.i2c_addr[7:0]] + 1;
                last_gap <= cyc - last_wr_done_cyc;
                if (bus.i2c_addr == last_wr_addr) retry_gap <= cyc - last_wr_done_cyc;
            end else begin
                rd_cnt[bus.i2c_addr[7:0]] <= rd_cnt[bus.i2c_addr[7:0]] + 1;
                rd_exec_cnt <= rd_exec_cnt + 1;
            end
        end else if (pend) begin
            if (lat == 0) begin
                pend <= 1'b0;
                bus.i2c_done <= 1'b1;
                if (!p_rh) begin
                    last_wr_done_cyc <= cyc;
                    last_wr_addr     <= p_addr;
                    if ((nack_left != 0) && (p_addr == nack_addr)) begin
                        bus.i2c_ack <= 1'b1;
                        if (nack_left > 0) nack_left <= nack_left - 1;
                    end else begin
                        bus.i2c_ack <= 1'b0;
                        mem[p_addr[7:0]] <= p_data;
                    end
                end else begin
                    bus.i2c_ack    <= 1'b0;
                    bus.i2c_data_r <= (bad_rd_en && (p_addr == bad_rd_addr)) ? 8'h00 : mem[p_addr[7:0]];
                end
            end else begin
                lat <= lat - 1;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic b_en, input logic [15:0] b_addr,
                         input logic [15:0] n_addr, input int n_cnt);
        bad_rd_en   = b_en;
        bad_rd_addr = b_addr;
        nack_addr   = n_addr;
        nack_cfg    = n_cnt;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && (n < TIMEOUT)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int exec_snap;
        int n;

        // Reset state
        setup(1'b0, 16'h0, 16'hFFFF, 0);
        repeat (2) @(negedge clk);
        check("rst_exec",   32'(bus.i2c_exec),   32'd0);
        check("rst_rh_wl",  32'(bus.i2c_rh_wl),  32'd0);
        check("rst_addr",   32'(bus.i2c_addr),   32'd0);
        check("rst_data_w", 32'(bus.i2c_data_w), 32'd0);
        check("rst_bitctl", 32'(bus.bit_ctrl),   32'd1);
        check("rst_busy",   32'(busy),           32'd0);
        check("rst_pass",   32'(pass),           32'd0);
        check("rst_fail",   32'(fail),           32'd0);
        check("rst_err",    32'(err_addr),       32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal pass
        pulse_start();
        check("t1_busy_on", 32'(busy), 32'd1);
        check("t1_exec_on", 32'(bus.i2c_exec), 32'd1);
        check("t1_addr0",   32'(bus.i2c_addr), 32'h0010);
        check("t1_data0",   32'(bus.i2c_data_w), 32'hA5);
        wait_idle("t1");
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_fail", 32'(fail), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_mem10", 32'(mem[8'h10]), 32'hA5);
        check("t1_mem11", 32'(mem[8'h11]), 32'hA4);
        check("t1_mem12", 32'(mem[8'h12]), 32'hA7);
        check("t1_mem13", 32'(mem[8'h13]), 32'hA6);
        check("t1_wr13",  32'(wr_cnt[8'h13]), 32'd1);
        check("t1_rd13",  32'(rd_cnt[8'h13]), 32'd1);
        check("t1_reads", 32'(rd_exec_cnt), 32'd4);
        check("t1_gap",   32'(last_gap), 32'(GAP_EXP));
        check("t1_proto", 32'(viol_exec), 32'd0);

        // Read mismatch at 0x12
        setup(1'b1, 16'h0012, 16'hFFFF, 0);
        pulse_start();
        check("t2_pass_clr", 32'(pass), 32'd0);
        wait_idle("t2");
        check("t2_fail", 32'(fail), 32'd1);
        check("t2_pass", 32'(pass), 32'd0);
        check("t2_err",  32'(err_addr), 32'h0012);
        check("t2_rd13", 32'(rd_cnt[8'h13]), 32'd0);
        check("t2_rd12", 32'(rd_cnt[8'h12]), 32'd1);

        // Single NACK on first write
        setup(1'b0, 16'h0, 16'h0010, 1);
        pulse_start();
        check("t3_fail_clr", 32'(fail), 32'd0);
        check("t3_err_clr",  32'(err_addr), 32'd0);
        wait_idle("t3");
`ifdef E2P_ACK_RETRY_EN
        check("t3_pass", 32'(pass), 32'd1);
        check("t3_fail", 32'(fail), 32'd0);
        check("t3_wr10", 32'(wr_cnt[8'h10]), 32'd2);
        check("t3_retry_gap", 32'(retry_gap), 32'(GAP_EXP));
`else
        check("t3_pass", 32'(pass), 32'd0);
        check("t3_fail", 32'(fail), 32'd1);
        check("t3_err",  32'(err_addr), 32'h0010);
        check("t3_wr10", 32'(wr_cnt[8'h10]), 32'd1);
        check("t3_reads", 32'(rd_exec_cnt), 32'd0);
`endif

        // Persistent NACK at 0x11
        setup(1'b0, 16'h0, 16'h0011, -1);
        pulse_start();
        wait_idle("t4");
        check("t4_fail", 32'(fail), 32'd1);
        check("t4_pass", 32'(pass), 32'd0);
        check("t4_err",  32'(err_addr), 32'h0011);
`ifdef E2P_ACK_RETRY_EN
        check("t4_wr11", 32'(wr_cnt[8'h11]), 32'd4);
`else
        check("t4_wr11", 32'(wr_cnt[8'h11]), 32'd1);
`endif
        check("t4_wr12", 32'(wr_cnt[8'h12]), 32'd0);

        // Reset during the second read
        setup(1'b0, 16'h0, 16'hFFFF, 0);
        pulse_start();
        n = 0;
        while ((rd_exec_cnt < 2) && (n < TIMEOUT)) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_rd2", 32'(rd_exec_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t5_busy",   32'(busy), 32'd0);
        check("t5_exec",   32'(bus.i2c_exec), 32'd0);
        check("t5_addr",   32'(bus.i2c_addr), 32'd0);
        check("t5_rh_wl",  32'(bus.i2c_rh_wl), 32'd0);
        check("t5_data_w", 32'(bus.i2c_data_w), 32'd0);
        check("t5_pf",     32'({pass, fail}), 32'd0);
        check("t5_err",    32'(err_addr), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exec_snap = exec_total;
        repeat (30) @(negedge clk);
        check("t5_no_resume_busy", 32'(busy), 32'd0);
        check("t5_no_resume_exec", 32'(exec_total), 32'(exec_snap));

        // Start while busy is ignored, start in DONE re-runs
        setup(1'b0, 16'h0, 16'hFFFF, 0);
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        wait_idle("t6");
        check("t6_pass", 32'(pass), 32'd1);
        check("t6_wr10", 32'(wr_cnt[8'h10]), 32'd1);
        check("t6_wr_total", 32'(exec_total), 32'd8);
        pulse_start();
        check("t6_rerun_pass_clr", 32'(pass), 32'd0);
        check("t6_rerun_busy", 32'(busy), 32'd1);
        wait_idle("t6b");
        check("t6_rerun_pass", 32'(pass), 32'd1);
        check("t6_rerun_wr10", 32'(wr_cnt[8'h10]), 32'd2);

        check("proto_exec", 32'(viol_exec), 32'd0);
        check("proto_pass_fail", 32'(viol_pf), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
